// File: rtl/reg_port_sched.sv
// Arbitrates operand-fetch read ports A/B and writeback port W onto the single-port register file.
// Optional build macro RR_READ_EN: round-robin A/B arbitration (default: A always beats B).
module reg_port_sched #(
    parameter int DATA_W     = 32,
    parameter int ID_W       = 4,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_valid,
    input  logic [ID_W-1:0]   a_reg_id,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [ID_W-1:0]   b_reg_id,
    output logic              b_ready,
    input  logic              w_valid,
    input  logic [ID_W-1:0]   w_reg_id,
    input  logic [DATA_W-1:0] w_data,
    output logic              w_ready,
    output logic              rsp_valid,
    output logic              rsp_port,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rf_rd,
    output logic              rf_wn,
    output logic [ID_W-1:0]   rf_reg_id,
    output logic [DATA_W-1:0] rf_write_data,
    input  logic [DATA_W-1:0] rf_read_data,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RD_CMD = 2'd1,
        RD_RSP = 2'd2,
        WR_CMD = 2'd3
    } state_t;

    state_t              state_r;
    state_t              state_nxt_s;
    logic [3:0]          starve_cnt_r;
    logic [3:0]          starve_cnt_nxt_s;
    logic                pend_port_r;
    logic                rsp_valid_r;
    logic                rsp_port_r;
    logic                rf_rd_r;
    logic                rf_wn_r;
    logic [ID_W-1:0]     rf_reg_id_r;
    logic [DATA_W-1:0]   rf_write_data_r;
    logic                rd_req_s;
    logic                force_rd_s;
    logic                sel_b_s;
    logic                gnt_w_s;
    logic                gnt_rd_s;
`ifdef RR_READ_EN
    logic                rr_ptr_r;
`endif

    // Arbitration, next-state and starvation-counter logic
    always_comb begin
        state_nxt_s      = IDLE;
        starve_cnt_nxt_s = starve_cnt_r;
        gnt_w_s          = 1'b0;
        gnt_rd_s         = 1'b0;
        rd_req_s         = a_valid | b_valid;
        force_rd_s       = rd_req_s && (starve_cnt_r == 4'(STARVE_MAX));
`ifdef RR_READ_EN
        if (a_valid && b_valid) begin
            sel_b_s = rr_ptr_r;
        end else begin
            sel_b_s = ~a_valid;
        end
`else
        sel_b_s = ~a_valid;
`endif
        // RD_CMD is the only state that cannot issue a new file command
        if (state_r != RD_CMD) begin
            if (w_valid && !force_rd_s) begin
                gnt_w_s = 1'b1;
            end else if (rd_req_s) begin
                gnt_rd_s = 1'b1;
            end else begin
                gnt_w_s  = 1'b0;
                gnt_rd_s = 1'b0;
            end
        end else begin
            gnt_w_s  = 1'b0;
            gnt_rd_s = 1'b0;
        end

        case (state_r)
            RD_CMD:                 state_nxt_s = RD_RSP;
            IDLE, RD_RSP, WR_CMD: begin
                if (gnt_w_s) begin
                    state_nxt_s = WR_CMD;
                end else if (gnt_rd_s) begin
                    state_nxt_s = RD_CMD;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            default:                state_nxt_s = IDLE;
        endcase

        if (!rd_req_s || gnt_rd_s) begin
            starve_cnt_nxt_s = 4'd0;
        end else if (gnt_w_s) begin
            starve_cnt_nxt_s = starve_cnt_r + 4'd1;
        end else begin
            starve_cnt_nxt_s = starve_cnt_r;
        end
    end

    // State, file-command and response registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r         <= IDLE;
            starve_cnt_r    <= 4'd0;
            pend_port_r     <= 1'b0;
            rsp_valid_r     <= 1'b0;
            rsp_port_r      <= 1'b0;
            rf_rd_r         <= 1'b0;
            rf_wn_r         <= 1'b0;
            rf_reg_id_r     <= {ID_W{1'b0}};
            rf_write_data_r <= {DATA_W{1'b0}};
        end else begin
            state_r      <= state_nxt_s;
            starve_cnt_r <= starve_cnt_nxt_s;
            rf_rd_r      <= gnt_rd_s;
            rf_wn_r      <= gnt_w_s;
            // the file returns data for the read issued one cycle earlier
            rsp_valid_r  <= (state_r == RD_CMD);
            if (state_r == RD_CMD) begin
                rsp_port_r <= pend_port_r;
            end else begin
                rsp_port_r <= rsp_port_r;
            end
            if (gnt_rd_s) begin
                rf_reg_id_r <= sel_b_s ? b_reg_id : a_reg_id;
                pend_port_r <= sel_b_s;
            end else if (gnt_w_s) begin
                rf_reg_id_r     <= w_reg_id;
                rf_write_data_r <= w_data;
            end else begin
                rf_reg_id_r <= rf_reg_id_r;
            end
        end
    end

`ifdef RR_READ_EN
    // Round-robin pointer: prefer the port not served by the latest read
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_r <= 1'b0;
        end else if (gnt_rd_s) begin
            rr_ptr_r <= ~sel_b_s;
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end
`endif

    assign w_ready       = gnt_w_s;
    assign a_ready       = gnt_rd_s & ~sel_b_s;
    assign b_ready       = gnt_rd_s & sel_b_s;
    assign rsp_valid     = rsp_valid_r;
    assign rsp_port      = rsp_port_r;
    assign rsp_data      = rf_read_data;
    assign rf_rd         = rf_rd_r;
    assign rf_wn         = rf_wn_r;
    assign rf_reg_id     = rf_reg_id_r;
    assign rf_write_data = rf_write_data_r;
    assign busy          = (state_r != IDLE);

endmodule

// File: tb/tb_reg_port_sched.sv
// Scoreboard bench for reg_port_sched with a behavioural 1-cycle-read register file.
module tb_reg_port_sched;
  localparam int DATA_W = 32;
  localparam int ID_W   = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              a_valid, b_valid, w_valid;
  logic [ID_W-1:0]   a_reg_id, b_reg_id, w_reg_id;
  logic [DATA_W-1:0] w_data;
  logic              a_ready, b_ready, w_ready;
  logic              rsp_valid, rsp_port;
  logic [DATA_W-1:0] rsp_data;
  logic              rf_rd, rf_wn;
  logic [ID_W-1:0]   rf_reg_id;
  logic [DATA_W-1:0] rf_write_data;
  logic [DATA_W-1:0] rf_read_data;
  logic              busy;
  logic              mem_init;
  logic [DATA_W-1:0] mem [16];

  int cyc = 0;
  int errors = 0;
  int checks = 0;

  typedef struct {
    logic              port;
    logic [DATA_W-1:0] data;
    int                cyc;
  } rd_exp_t;
  typedef struct {
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] data;
    int                cyc;
  } wr_exp_t;
  rd_exp_t rd_q[$];
  wr_exp_t wr_q[$];

  reg_port_sched dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_reg_id(a_reg_id), .a_ready(a_ready),
    .b_valid(b_valid), .b_reg_id(b_reg_id), .b_ready(b_ready),
    .w_valid(w_valid), .w_reg_id(w_reg_id), .w_data(w_data), .w_ready(w_ready),
    .rsp_valid(rsp_valid), .rsp_port(rsp_port), .rsp_data(rsp_data),
    .rf_rd(rf_rd), .rf_wn(rf_wn), .rf_reg_id(rf_reg_id),
    .rf_write_data(rf_write_data), .rf_read_data(rf_read_data), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // register file model: write at end of the wn cycle, registered read
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'hA5A5_0000 | 32'(i);
      rf_read_data <= 32'h0;
    end else begin
      if (rf_wn) mem[rf_reg_id] <= rf_write_data;
      if (rf_rd) rf_read_data <= mem[rf_reg_id];
    end
  end

  // monitor: pops expectations whenever the DUT presents a response or write command
  always @(negedge clk) begin
    if (!rst && !mem_init) begin
      checks++;
      if (rf_rd && rf_wn) begin
        errors++;
        $display("FAIL rd_wn_excl: rf_rd=%0b rf_wn=%0b required not both 1", rf_rd, rf_wn);
      end
      if (rsp_valid) begin
        checks++;
        if (rd_q.size() == 0) begin
          errors++;
          $display("FAIL rsp_unexpected: port=%0d data=%h at cyc %0d, required no response", rsp_port, rsp_data, cyc);
        end else begin
          rd_exp_t e;
          e = rd_q.pop_front();
          if (rsp_port !== e.port || rsp_data !== e.data || cyc != e.cyc) begin
            errors++;
            $display("FAIL rsp: got port=%0d data=%h cyc=%0d required port=%0d data=%h cyc=%0d",
                     rsp_port, rsp_data, cyc, e.port, e.data, e.cyc);
          end
        end
      end
      if (rf_wn) begin
        checks++;
        if (wr_q.size() == 0) begin
          errors++;
          $display("FAIL wr_unexpected: id=%0d data=%h at cyc %0d", rf_reg_id, rf_write_data, cyc);
        end else begin
          wr_exp_t w;
          w = wr_q.pop_front();
          if (rf_reg_id !== w.id || rf_write_data !== w.data || cyc != w.cyc) begin
            errors++;
            $display("FAIL wr_cmd: got id=%0d data=%h cyc=%0d required id=%0d data=%h cyc=%0d",
                     rf_reg_id, rf_write_data, cyc, w.id, w.data, w.cyc);
          end
        end
      end
    end
  end

  task automatic rd_req(input logic port, input logic [ID_W-1:0] id, input logic [DATA_W-1:0] exp,
                        input bit expect_rsp, output int acc);
    bit got = 1'b0;
    acc = -1;
    if (!port) begin a_valid = 1'b1; a_reg_id = id; end
    else begin b_valid = 1'b1; b_reg_id = id; end
    for (int n = 0; n < 50 && !got; n++) begin
      @(negedge clk);
      if (port ? b_ready : a_ready) got = 1'b1;
    end
    checks++;
    if (got) begin
      acc = cyc + 1;
      if (expect_rsp) rd_q.push_back('{port, exp, acc + 1});
      @(posedge clk);
      #1;
    end else begin
      errors++;
      $display("FAIL rd_accept: port %0d got no ready, required ready within 50 cycles", port);
    end
    if (!port) a_valid = 1'b0;
    else b_valid = 1'b0;
  endtask

  task automatic wr_req(input logic [ID_W-1:0] id, input logic [DATA_W-1:0] data, output int acc);
    bit got = 1'b0;
    acc = -1;
    w_valid = 1'b1; w_reg_id = id; w_data = data;
    for (int n = 0; n < 50 && !got; n++) begin
      @(negedge clk);
      if (w_ready) got = 1'b1;
    end
    checks++;
    if (got) begin
      acc = cyc + 1;
      wr_q.push_back('{id, data, acc});
      @(posedge clk);
      #1;
    end else begin
      errors++;
      $display("FAIL wr_accept: no w_ready, required ready within 50 cycles");
    end
    w_valid = 1'b0;
  endtask

  task automatic chk(input string name, input int got, input int req);
    checks++;
    if (got != req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, got, req);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, aa, ba, ra, x0, x1, seen;
    int wacc[10];
    a_valid = 1'b0; b_valid = 1'b0; w_valid = 1'b0;
    a_reg_id = '0; b_reg_id = '0; w_reg_id = '0; w_data = '0;
    rst = 1'b1; mem_init = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_state", {rf_rd, rf_wn, rsp_valid, rsp_port, busy, (rf_reg_id != 4'd0),
                        (rf_write_data != 32'd0)}, 0);
    @(posedge clk); #1;
    rst = 1'b0; mem_init = 1'b0;

    // write r3 then read it back on A
    wr_req(4'd3, 32'hDEAD_BEEF, acc);
    rd_req(1'b0, 4'd3, 32'hDEAD_BEEF, 1'b1, acc);
    repeat (3) @(posedge clk); #1;

    // A and B together: A first, B two cycles later
    fork
      rd_req(1'b0, 4'd1, 32'hA5A5_0001, 1'b1, aa);
      rd_req(1'b1, 4'd2, 32'hA5A5_0002, 1'b1, ba);
    join
    chk("ab_order", ba, aa + 2);
    repeat (3) @(posedge clk); #1;

    // W held with A pending: 4 writes, then A, then writes resume
    fork
      begin
        for (int i = 0; i < 10; i++) wr_req(4'd7, 32'h100 + 32'(i), wacc[i]);
      end
      rd_req(1'b0, 4'd7, 32'h0000_0103, 1'b1, ra);
    join
    chk("starve_b2b_w", wacc[3], wacc[0] + 3);
    chk("starve_a_grant", ra, wacc[3] + 1);
    chk("starve_w_resume", wacc[4], ra + 2);
    repeat (3) @(posedge clk); #1;

    // back-to-back writes to r5, later read returns the second
    wr_req(4'd5, 32'h1, x0);
    wr_req(4'd5, 32'h2, x1);
    chk("wr_b2b", x1, x0 + 1);
    rd_req(1'b0, 4'd5, 32'h2, 1'b1, acc);
    repeat (3) @(posedge clk); #1;

    // reset while the read is in RD_CMD: the response must be dropped
    rd_req(1'b0, 4'd4, 32'h0, 1'b0, acc);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_rd_cmd", {busy, rsp_valid, rf_rd}, 0);
    rst = 1'b0;
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    chk("no_rsp_after_rst", seen, 0);

    // idle bus
    repeat (5) begin
      @(negedge clk);
      chk("idle", {rf_rd, rf_wn, busy, a_ready, b_ready, w_ready}, 0);
    end

    chk("sb_drain", rd_q.size() + wr_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
